// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. Sits in IF: gives a same-cycle hit / taken / next-PC
//   prediction for the fetch PC. Resolved branches from EX train the table.
//   The block also flags mispredictions with a redirect PC and keeps
//   branch and misprediction counts.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   PC_IF             fetch PC (bits [1:0] not used for index/tag)
//   BTBhit_IF         lookup hit
//   Branch_P_IF       predicted taken
//   PredNPC_IF        predicted next PC
//   BrValid_EX        conditional branch resolving in EX
//   StallE            EX held; suppresses training and statistics
//   PC_EX             PC of the resolving branch
//   BrTaken_EX        actual outcome
//   BrTarget_EX       actual taken target
//   Branch_P_EX       prediction carried down the pipe
//   BTBhit_EX         hit flag carried down the pipe (not used for training)
//   PredNPC_EX        predicted next PC carried down the pipe
//   Mispredict_EX     flush request
//   CorrectNPC_EX     redirect PC, meaningful when Mispredict_EX=1
//   BrCount           resolved branch count (wraps)
//   MissCount         misprediction count (wraps)
// ---------------------------------------------------------------------------
module btb_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  output logic        BTBhit_IF,
  output logic        Branch_P_IF,
  output logic [31:0] PredNPC_IF,
  input  logic        BrValid_EX,
  input  logic        StallE,
  input  logic [31:0] PC_EX,
  input  logic        BrTaken_EX,
  input  logic [31:0] BrTarget_EX,
  input  logic        Branch_P_EX,
  input  logic        BTBhit_EX,
  input  logic [31:0] PredNPC_EX,
  output logic        Mispredict_EX,
  output logic [31:0] CorrectNPC_EX,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic             valid_q  [ENTRIES];
  logic [TAGW-1:0]  tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];

  logic [IDXW-1:0]  idx_if, idx_ex;
  logic [TAGW-1:0]  tag_if, tag_ex;
  logic             hit_ex;
  logic             train;
  logic             unused_hit_ex;

  // The carried hit flag is informational only; training re-probes the table.
  assign unused_hit_ex = BTBhit_EX;

  assign idx_if = PC_IF[IDXW+1:2];
  assign tag_if = PC_IF[31:IDXW+2];
  assign idx_ex = PC_EX[IDXW+1:2];
  assign tag_ex = PC_EX[31:IDXW+2];

  // Same-cycle lookup; reads pre-update contents when EX writes the same index.
  assign BTBhit_IF   = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign Branch_P_IF = BTBhit_IF && cnt_q[idx_if][1];
  assign PredNPC_IF  = Branch_P_IF ? target_q[idx_if] : PC_IF + 32'd4;

  assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
  assign train  = BrValid_EX && !StallE;

  // A taken prediction can still be wrong if the carried target is stale.
  assign Mispredict_EX = BrValid_EX &&
                         ((Branch_P_EX != BrTaken_EX) ||
                          (Branch_P_EX && BrTaken_EX && (PredNPC_EX != BrTarget_EX)));
  assign CorrectNPC_EX = BrTaken_EX ? BrTarget_EX : PC_EX + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
      BrCount   <= '0;
      MissCount <= '0;
    end else if (train) begin
      BrCount <= BrCount + 32'd1;
      if (Mispredict_EX) begin
        MissCount <= MissCount + 32'd1;
      end
      if (hit_ex) begin
        if (BrTaken_EX) begin
          if (cnt_q[idx_ex] != 2'b11) begin
            cnt_q[idx_ex] <= cnt_q[idx_ex] + 2'd1;
          end
          target_q[idx_ex] <= BrTarget_EX;
        end else if (cnt_q[idx_ex] != 2'b00) begin
          cnt_q[idx_ex] <= cnt_q[idx_ex] - 2'd1;
        end
      end else if (BrTaken_EX) begin
        // Allocation overwrites whatever alias occupied the slot.
        valid_q[idx_ex]  <= 1'b1;
        tag_q[idx_ex]    <= tag_ex;
        target_q[idx_ex] <= BrTarget_EX;
        cnt_q[idx_ex]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF;
  logic        BTBhit_IF, Branch_P_IF;
  logic [31:0] PredNPC_IF;
  logic        BrValid_EX, StallE, BrTaken_EX, Branch_P_EX, BTBhit_EX;
  logic [31:0] PC_EX, BrTarget_EX, PredNPC_EX;
  logic        Mispredict_EX;
  logic [31:0] CorrectNPC_EX, BrCount, MissCount;

  always #5 clk = ~clk;

  btb_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .PC_IF(PC_IF),
    .BTBhit_IF(BTBhit_IF), .Branch_P_IF(Branch_P_IF), .PredNPC_IF(PredNPC_IF),
    .BrValid_EX(BrValid_EX), .StallE(StallE), .PC_EX(PC_EX),
    .BrTaken_EX(BrTaken_EX), .BrTarget_EX(BrTarget_EX),
    .Branch_P_EX(Branch_P_EX), .BTBhit_EX(BTBhit_EX), .PredNPC_EX(PredNPC_EX),
    .Mispredict_EX(Mispredict_EX), .CorrectNPC_EX(CorrectNPC_EX),
    .BrCount(BrCount), .MissCount(MissCount)
  );

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: each slot remembers which branch (by word address) owns
  // it, its target and an integer confidence 0..3.
  bit          m_valid [ENTRIES];
  logic [31:0] m_word  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_brc, m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_word[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_brc = '0; m_miss = '0;
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_word[slot(pc)] == (pc >> 2));
  endfunction

  function automatic bit m_mispredict();
    if (!BrValid_EX) return 0;
    if (Branch_P_EX != BrTaken_EX) return 1;
    return Branch_P_EX && BrTaken_EX && (PredNPC_EX != BrTarget_EX);
  endfunction

  // One clock: check combinational outputs late in the cycle, advance the
  // model at the edge, then check the counters just after it.
  task automatic step();
    int s; bit h, p, mp; logic [31:0] npc;
    #2;
    s   = slot(PC_IF);
    h   = m_hit(PC_IF);
    p   = h && (m_cnt[s] >= 2);
    npc = p ? m_tgt[s] : PC_IF + 32'd4;
    mp  = m_mispredict();
    chk("hit_if", {31'd0, BTBhit_IF}, {31'd0, h});
    chk("taken_if", {31'd0, Branch_P_IF}, {31'd0, p});
    chk("npc_if", PredNPC_IF, npc);
    chk("mispredict", {31'd0, Mispredict_EX}, {31'd0, mp});
    if (mp) chk("correct_npc", CorrectNPC_EX, BrTaken_EX ? BrTarget_EX : PC_EX + 32'd4);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (BrValid_EX && !StallE) begin
      s = slot(PC_EX);
      m_brc++;
      if (mp) m_miss++;
      if (m_hit(PC_EX)) begin
        if (BrTaken_EX) begin
          m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
          m_tgt[s] = BrTarget_EX;
        end else begin
          m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
        end
      end else if (BrTaken_EX) begin
        m_valid[s] = 1; m_word[s] = PC_EX >> 2; m_tgt[s] = BrTarget_EX; m_cnt[s] = 2;
      end
    end
    #1;
    chk("br_count", BrCount, m_brc);
    chk("miss_count", MissCount, m_miss);
  endtask

  task automatic idle(input logic [31:0] pc);
    PC_IF = pc; BrValid_EX = 0; StallE = 0; PC_EX = '0; BrTaken_EX = 0;
    BrTarget_EX = '0; Branch_P_EX = 0; BTBhit_EX = 0; PredNPC_EX = '0;
  endtask

  task automatic br(input logic [31:0] pc_if, input logic [31:0] pcx, input bit tk,
                    input logic [31:0] tgt, input bit bp, input logic [31:0] pnx, input bit stall);
    PC_IF = pc_if; BrValid_EX = 1; StallE = stall; PC_EX = pcx; BrTaken_EX = tk;
    BrTarget_EX = tgt; Branch_P_EX = bp; BTBhit_EX = bp; PredNPC_EX = pnx;
  endtask

  // Explicit directed expectations for the current lookup.
  task automatic expect_if(input string tag, input bit h, input bit p, input logic [31:0] npc);
    #1;
    chk({tag, "_hit"}, {31'd0, BTBhit_IF}, {31'd0, h});
    chk({tag, "_taken"}, {31'd0, Branch_P_IF}, {31'd0, p});
    chk({tag, "_npc"}, PredNPC_IF, npc);
  endtask

  logic [31:0] pool [8];
  logic [31:0] tgts [4];
  logic [31:0] brc_before;

  initial begin
    model_reset();
    idle(32'h100);
    rst = 1;
    @(posedge clk); #1;
    step();
    rst = 0;

    // cold miss
    idle(32'h100);
    expect_if("cold", 0, 0, 32'h104);
    chk("cold_mispredict", {31'd0, Mispredict_EX}, 32'd0);
    step();

    // allocate, then hit
    br(32'h100, 32'h100, 1, 32'h200, 0, 32'h104, 0);
    #1;
    chk("alloc_mispredict", {31'd0, Mispredict_EX}, 32'd1);
    chk("alloc_correct", CorrectNPC_EX, 32'h200);
    step();
    chk("alloc_brc", BrCount, 32'd1);
    chk("alloc_miss", MissCount, 32'd1);
    idle(32'h100);
    expect_if("alloc_hit", 1, 1, 32'h200);
    step();

    // saturation: 3 taken then 2 not-taken ends at cnt=1
    for (int k = 0; k < 3; k++) begin br(32'h0, 32'h100, 1, 32'h200, 1, 32'h200, 0); step(); end
    for (int k = 0; k < 2; k++) begin br(32'h0, 32'h100, 0, 32'h200, 1, 32'h200, 0); step(); end
    idle(32'h100);
    expect_if("sat", 1, 0, 32'h104);
    step();

    // not-taken miss allocates nothing
    br(32'h0, 32'h300, 0, 32'h400, 0, 32'h304, 0); step();
    idle(32'h300);
    expect_if("nt_miss", 0, 0, 32'h304);
    step();

    // alias eviction
    br(32'h0, 32'h100, 1, 32'h200, 0, 32'h104, 0); step();
    br(32'h0, 32'h100 + 4 * ENTRIES, 1, 32'h500, 0, 32'h204, 0); step();
    idle(32'h100);
    expect_if("alias_old", 0, 0, 32'h104);
    step();
    idle(32'h100 + 4 * ENTRIES);
    expect_if("alias_new", 1, 1, 32'h500);
    step();

    // target mismatch
    br(32'h0, 32'h100, 1, 32'h200, 0, 32'h104, 0); step();
    br(32'h0, 32'h100, 1, 32'h240, 1, 32'h200, 0);
    #1;
    chk("tgt_mispredict", {31'd0, Mispredict_EX}, 32'd1);
    chk("tgt_correct", CorrectNPC_EX, 32'h240);
    step();
    idle(32'h100);
    expect_if("tgt_new", 1, 1, 32'h240);
    step();

    // same-cycle update and lookup: lookup sees old contents
    br(32'h300, 32'h300, 1, 32'h380, 0, 32'h304, 0);
    expect_if("nobypass", 0, 0, 32'h304);
    step();
    idle(32'h300);
    expect_if("after_bypass", 1, 1, 32'h380);
    step();

    // stalled branch trained exactly once
    brc_before = BrCount;
    for (int k = 0; k < 3; k++) begin br(32'h0, 32'h600, 1, 32'h700, 0, 32'h604, 1); step(); end
    br(32'h0, 32'h600, 1, 32'h700, 0, 32'h604, 0); step();
    idle(32'h600);
    step();
    chk("stall_once", BrCount - brc_before, 32'd1);

    // reset wins over training
    br(32'h0, 32'h800, 1, 32'h900, 0, 32'h804, 0);
    rst = 1; step(); rst = 0;
    idle(32'h100);
    expect_if("rst_entry", 0, 0, 32'h104);
    chk("rst_brc", BrCount, 32'd0);
    chk("rst_miss", MissCount, 32'd0);
    step();
    idle(32'h800);
    expect_if("rst_train", 0, 0, 32'h804);
    step();

    // randomized traffic over a small aliasing PC pool
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h300;
    pool[3] = 32'h100 + 4 * ENTRIES; pool[4] = 32'h1000; pool[5] = 32'h1004;
    pool[6] = 32'hFFFF_FFFC; pool[7] = 32'h100 + 8 * ENTRIES;
    tgts[0] = 32'h200; tgts[1] = 32'h240; tgts[2] = 32'h4000; tgts[3] = 32'h0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pcx, tg;
      pcx = pool[$urandom_range(7)];
      tg  = tgts[$urandom_range(3)];
      if ($urandom_range(3) == 0) idle(pool[$urandom_range(7)]);
      else br(pool[$urandom_range(7)], pcx, 1'($urandom_range(1)), tg,
              1'($urandom_range(1)), $urandom_range(1) ? tg : pcx + 32'd4,
              $urandom_range(4) == 0);
      rst = ($urandom_range(60) == 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
